// File: rtl/rv_decode_pipe.sv
// Registered RV32IM decode stage between IF and EX.
// Emits an 11-bit control word, an illegal flag and the PC; stalls while MUL/DIV is busy.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   flush              drop held output, clear M-unit busy counter
//   in_valid/in_ready  upstream handshake for instr/in_pc
//   instr, in_pc       raw instruction and its PC
//   out_valid/out_ready downstream handshake for control/illegal/out_pc
//   control            {en, rw, alu[3:0], src, mr, mw, br, m2r}
//   illegal            unsupported opcode/funct combination
//   out_pc             registered in_pc
//   mdu_busy           M-unit busy counter nonzero
module rv_decode_pipe #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [10:0]     control,
    output logic            illegal,
    output logic [XLEN-1:0] out_pc,
    output logic            mdu_busy
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // Register fields do not affect control decode.
    logic unused_fields;
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // Shared R/I ALU code for the base (non-alternate) funct3 values.
    function automatic logic [3:0] alu_of(input logic [2:0] fn);
        logic [3:0] a;
        case (fn)
            3'd0:    a = 4'b0000;
            3'd1:    a = 4'b0101;
            3'd2:    a = 4'b0100;
            3'd3:    a = 4'b1010;
            3'd4:    a = 4'b1000;
            3'd5:    a = 4'b0110;
            3'd6:    a = 4'b0010;
            default: a = 4'b0011;
        endcase
        return a;
    endfunction

    logic       d_en;
    logic       d_rw;
    logic [3:0] d_alu;
    logic       d_src;
    logic       d_mr;
    logic       d_mw;
    logic       d_br;
    logic       d_m2r;
    logic       d_ill;
    logic       d_is_m;
    logic [10:0] d_ctrl;

    always_comb begin
        d_en   = 1'b0;
        d_rw   = 1'b0;
        d_alu  = 4'b0000;
        d_src  = 1'b0;
        d_mr   = 1'b0;
        d_mw   = 1'b0;
        d_br   = 1'b0;
        d_m2r  = 1'b0;
        d_ill  = 1'b1;
        d_is_m = 1'b0;
        case (opcode)
            OP_R: begin
                if (f7 == F7_M) begin
                    d_rw   = 1'b1;
                    d_alu  = {1'b0, f3};
                    d_ill  = 1'b0;
                    d_is_m = 1'b1;
                end else if (f7 == F7_ZERO) begin
                    d_en  = 1'b1;
                    d_rw  = 1'b1;
                    d_alu = alu_of(f3);
                    d_ill = 1'b0;
                end else if (f7 == F7_ALT) begin
                    d_en = 1'b1;
                    d_rw = 1'b1;
                    if (f3 == 3'd0) begin
                        d_alu = 4'b0001;
                        d_ill = 1'b0;
                    end else if (f3 == 3'd5) begin
                        d_alu = 4'b1001;
                        d_ill = 1'b0;
                    end
                end
            end
            OP_I: begin
                d_en  = 1'b1;
                d_rw  = 1'b1;
                d_src = 1'b1;
                d_alu = alu_of(f3);
                // Only shifts reuse f7; elsewhere those bits are immediate.
                case (f3)
                    3'd1: d_ill = (f7 != F7_ZERO);
                    3'd5: begin
                        if (f7 == F7_ZERO) begin
                            d_ill = 1'b0;
                        end else if (f7 == F7_ALT) begin
                            d_alu = 4'b1001;
                            d_ill = 1'b0;
                        end
                    end
                    default: d_ill = 1'b0;
                endcase
            end
            OP_LD: begin
                d_en  = 1'b1;
                d_rw  = 1'b1;
                d_src = 1'b1;
                d_mr  = 1'b1;
                d_m2r = 1'b1;
                d_ill = 1'b0;
            end
            OP_ST: begin
                d_en  = 1'b1;
                d_src = 1'b1;
                d_mw  = 1'b1;
                d_ill = 1'b0;
            end
            OP_BR: begin
                d_en = 1'b1;
                d_br = 1'b1;
                case (f3)
                    3'd0, 3'd1: begin
                        d_alu = 4'b0001;
                        d_ill = 1'b0;
                    end
                    3'd4, 3'd6: begin
                        d_alu = 4'b0100;
                        d_ill = 1'b0;
                    end
                    3'd5, 3'd7: begin
                        d_alu = 4'b0111;
                        d_ill = 1'b0;
                    end
                    default: d_ill = 1'b1;
                endcase
            end
            OP_JAL, OP_JALR: begin
                d_en  = 1'b1;
                d_rw  = 1'b1;
                d_src = 1'b1;
                d_br  = 1'b1;
                d_ill = 1'b0;
            end
            OP_AUI: begin
                d_en  = 1'b1;
                d_rw  = 1'b1;
                d_src = 1'b1;
                d_ill = 1'b0;
            end
            OP_LUI: begin
                d_en  = 1'b1;
                d_rw  = 1'b1;
                d_alu = 4'b1011;
                d_src = 1'b1;
                d_ill = 1'b0;
            end
            default: d_ill = 1'b1;
        endcase
        // Illegal words carry an all-zero control word.
        if (d_ill) begin
            d_ctrl = 11'd0;
        end else begin
            d_ctrl = {d_en, d_rw, d_alu, d_src,
                      d_mr, d_mw, d_br, d_m2r};
        end
    end

    logic [CNT_W-1:0] busy;
    logic             accept;

    assign mdu_busy = (busy != '0);
    assign in_ready = !flush && !mdu_busy
                   && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            control   <= 11'd0;
            illegal   <= 1'b0;
            out_pc    <= '0;
            busy      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            busy      <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                control   <= d_ctrl;
                illegal   <= d_ill;
                out_pc    <= in_pc;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // d_is_m is only set on legal M words.
            if (accept && d_is_m) begin
                busy <= f3[2] ? DIV_LOAD : MUL_LOAD;
            end else if (mdu_busy) begin
                busy <= busy - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv_decode_pipe.sv
// Directed bench for rv_decode_pipe.
// Hand-computed control words, handshake stalls, M-unit busy and flush.
module tb_rv_decode_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] control;
    logic        illegal;
    logic [31:0] out_pc;
    logic        mdu_busy;

    int total;
    int bad;
    int sent;
    int rcvd;
    int stall;
    logic [31:0] held_pc;
    logic [10:0] held_ctrl;

    rv_decode_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .control   (control),
        .illegal   (illegal),
        .out_pc    (out_pc),
        .mdu_busy  (mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag,
                            input logic [31:0] ins,
                            input logic [31:0] pc,
                            input logic [10:0] ectrl,
                            input logic        eill);
        int n;
        instr     = ins;
        in_pc     = pc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_ctl"}, 32'(control), 32'(ectrl));
        check({tag, "_ill"}, 32'(illegal), 32'(eill));
        check({tag, "_pc"}, out_pc, pc);
        tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_ctl", 32'(control), 32'd0);
        check("rst_ill", 32'(illegal), 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_busy", 32'(mdu_busy), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);

        // ADD x1,x2,x3
        send_one("add", 32'h003100B3, 32'h100, 11'h600, 1'b0);
        check("add_deq", 32'(out_valid), 32'd0);

        // MUL then ADD back-to-back
        instr    = 32'h023100B3;
        in_pc    = 32'h200;
        in_valid = 1'b1;
        tick();
        check("mul_ctl", 32'(control), 32'h200);
        check("mul_busy", 32'(mdu_busy), 32'd1);
        instr = 32'h003100B3;
        in_pc = 32'h204;
        check("mul_st1", 32'(in_ready), 32'd0);
        tick();
        check("mul_st2", 32'(in_ready), 32'd0);
        check("mul_deq", 32'(out_valid), 32'd0);
        tick();
        check("mul_go", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("mul_add_vld", 32'(out_valid), 32'd1);
        check("mul_add_pc", out_pc, 32'h204);
        check("mul_add_ctl", 32'(control), 32'h600);
        tick();

        // DIV then flush one cycle later
        instr    = 32'h023140B3;
        in_pc    = 32'h300;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("div_ctl", 32'(control), 32'h280);
        check("div_busy", 32'(mdu_busy), 32'd1);
        flush = 1'b1;
        #1;
        check("fl_rdy", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("fl_vld", 32'(out_valid), 32'd0);
        check("fl_busy", 32'(mdu_busy), 32'd0);
        #1;
        check("fl_rdy2", 32'(in_ready), 32'd1);
        tick();

        // Four LW with out_ready 1,0,0,1
        sent  = 0;
        rcvd  = 0;
        instr = 32'h0020A083;
        for (int c = 0; c < 20 && rcvd < 4; c++) begin
            out_ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
            in_valid  = (sent < 4);
            in_pc     = 32'h400 + 32'(4 * sent);
            #1;
            stall = 0;
            if (out_valid && out_ready) begin
                check("lw_pc", out_pc, 32'h400 + 32'(4 * rcvd));
                check("lw_ctl", 32'(control), 32'h619);
                rcvd++;
            end
            if (out_valid && !out_ready) begin
                check("lw_st_rdy", 32'(in_ready), 32'd0);
                held_pc   = out_pc;
                held_ctrl = control;
                stall     = 1;
            end
            if (in_valid && in_ready) sent++;
            tick();
            if (stall != 0) begin
                check("lw_hold_pc", out_pc, held_pc);
                check("lw_hold_ctl", 32'(control), 32'(held_ctrl));
                check("lw_hold_vld", 32'(out_valid), 32'd1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("lw_rcvd", 32'(rcvd), 32'd4);
        check("lw_sent", 32'(sent), 32'd4);
        tick();
        check("lw_empty", 32'(out_valid), 32'd0);

        // Illegal words
        send_one("bad_op", 32'h0000007F, 32'h500, 11'h000, 1'b1);
        check("bad_busy", 32'(mdu_busy), 32'd0);
        send_one("beq_f2", 32'h00002063, 32'h504, 11'h000, 1'b1);
        check("beq_busy", 32'(mdu_busy), 32'd0);
        send_one("slli_f7", 32'h40109093, 32'h508, 11'h000, 1'b1);

        // Jumps, LUI and a few ALU variants
        send_one("jalr", 32'h000080E7, 32'h12345678, 11'h612, 1'b0);
        send_one("lui", 32'h123450B7, 32'h0000ABC0, 11'h770, 1'b0);
        send_one("sub", 32'h403100B3, 32'h600, 11'h620, 1'b0);
        send_one("srai", 32'h4010D093, 32'h604, 11'h730, 1'b0);
        send_one("bge", 32'h00005063, 32'h608, 11'h4E2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
